// File: rtl/guvm_obi_responder.sv
// guvm_obi_responder: OBI req/gnt/rvalid memory-side responder with stimulus FIFO; `define GUVM_RESP_RANDOM_STALL_EN adds LFSR grant stalls
module guvm_obi_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int GNT_DELAY = 0,
  parameter int RVALID_DELAY = 1,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STIM_DEPTH = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = DATA_WIDTH'(32'hDEADBEEF)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     req_i,
  input  logic [ADDR_WIDTH-1:0]                    addr_i,
  input  logic                                     we_i,
  input  logic [DATA_WIDTH/8-1:0]                  be_i,
  input  logic [DATA_WIDTH-1:0]                    wdata_i,
  output logic                                     gnt_o,
  output logic                                     rvalid_o,
  output logic [DATA_WIDTH-1:0]                    rdata_o,
  input  logic                                     stim_valid_i,
  input  logic [DATA_WIDTH-1:0]                    stim_data_i,
  output logic                                     stim_ready_o,
  output logic                                     wr_valid_o,
  output logic [ADDR_WIDTH-1:0]                    wr_addr_o,
  output logic [DATA_WIDTH-1:0]                    wr_data_o,
  output logic [DATA_WIDTH/8-1:0]                  wr_be_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic                                     underflow_o
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (STIM_DEPTH > 1) ? $clog2(STIM_DEPTH) : 1;
  localparam int CW = $clog2(STIM_DEPTH + 1);
  localparam int GW = $clog2(GNT_DELAY + 2);

  typedef enum logic [1:0] {IDLE, WAIT, GRANT_OK} state_t;

  state_t state, state_n;
  logic [GW-1:0] cnt, cnt_n;
  logic stall, can_grant;
  logic [DATA_WIDTH-1:0] mem [STIM_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic push, pop, empty;
  logic [RVALID_DELAY-1:0] pipe_v, pipe_w;
  logic [RVALID_DELAY:0] chain_v, chain_w;
  logic resp_v, resp_we, resp_rd;

`ifdef GUVM_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk_i)
    lfsr <= rst_i ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign stall = lfsr[1:0] == 2'b00;
`else
  assign stall = 1'b0;
`endif

  assign can_grant = req_i && (outstanding_o < OW'(MAX_OUTSTANDING)) && !stall;

  // cnt counts req cycles held, including the current one
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    gnt_o = 1'b0;
    case (state)
      IDLE:
        if (req_i) begin
          if (GNT_DELAY == 0) begin
            gnt_o = can_grant;
            state_n = GRANT_OK;
          end else begin
            cnt_n = GW'(1);
            state_n = (GNT_DELAY <= 1) ? GRANT_OK : WAIT;
          end
        end
      WAIT:
        if (!req_i) state_n = IDLE;
        else begin
          cnt_n = cnt + GW'(1);
          state_n = (cnt_n == GW'(GNT_DELAY)) ? GRANT_OK : WAIT;
        end
      GRANT_OK: begin
        gnt_o = can_grant;
        state_n = (can_grant && GNT_DELAY != 0) ? IDLE : GRANT_OK;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end

  // stage input of index i is chain[i]; the last stage doubles as rvalid_o
  assign chain_v = {pipe_v, gnt_o};
  assign chain_w = {pipe_w, gnt_o && we_i};
  assign resp_v = chain_v[RVALID_DELAY-1];
  assign resp_we = chain_w[RVALID_DELAY-1];
  assign resp_rd = resp_v && !resp_we;
  assign rvalid_o = pipe_v[RVALID_DELAY-1];

  assign empty = count == '0;
  assign stim_ready_o = count != CW'(STIM_DEPTH);
  assign push = stim_valid_i && stim_ready_o;
  assign pop = resp_rd && !empty;

  always_ff @(posedge clk_i)
    if (push) mem[wptr] <= stim_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      pipe_v <= '0;
      pipe_w <= '0;
      rdata_o <= '0;
      underflow_o <= 1'b0;
      outstanding_o <= '0;
      wr_valid_o <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      wr_be_o <= '0;
    end else begin
      wptr <= push ? wptr + PW'(1) : wptr;
      rptr <= pop ? rptr + PW'(1) : rptr;
      count <= count + CW'(push) - CW'(pop);
      pipe_v <= chain_v[RVALID_DELAY-1:0];
      pipe_w <= chain_w[RVALID_DELAY-1:0];
      rdata_o <= !resp_rd ? '0 : empty ? DEFAULT_RDATA : mem[rptr];
      underflow_o <= underflow_o || (resp_rd && empty);
      outstanding_o <= outstanding_o + OW'(gnt_o) - OW'(resp_v);
      wr_valid_o <= gnt_o && we_i;
      if (gnt_o && we_i) begin
        wr_addr_o <= addr_i;
        wr_data_o <= wdata_i;
        wr_be_o <= be_i;
      end
    end
  end
endmodule

// File: tb/tb_guvm_obi_responder.sv
// tb_guvm_obi_responder: directed checks on three responder configurations (G0/R1, G2/R3, G0/R4)
module tb_guvm_obi_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req [3], we [3], stim_valid [3];
  logic [31:0] addr [3], wdata [3], stim_data [3];
  logic [3:0] be [3];
  logic gnt [3], rvalid [3], stim_ready [3], wr_valid [3], underflow [3];
  logic [31:0] rdata [3], wr_addr [3], wr_data [3];
  logic [3:0] wr_be [3];
  logic [1:0] outstanding [3];
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    guvm_obi_responder #(
      .GNT_DELAY(g == 1 ? 2 : 0),
      .RVALID_DELAY(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .MAX_OUTSTANDING(2)
    ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req[g]), .addr_i(addr[g]), .we_i(we[g]),
      .be_i(be[g]), .wdata_i(wdata[g]), .gnt_o(gnt[g]), .rvalid_o(rvalid[g]),
      .rdata_o(rdata[g]), .stim_valid_i(stim_valid[g]), .stim_data_i(stim_data[g]),
      .stim_ready_o(stim_ready[g]), .wr_valid_o(wr_valid[g]), .wr_addr_o(wr_addr[g]),
      .wr_data_o(wr_data[g]), .wr_be_o(wr_be[g]), .outstanding_o(outstanding[g]),
      .underflow_o(underflow[g])
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int k, input logic [31:0] d);
    stim_valid[k] = 1'b1;
    stim_data[k] = d;
    tick();
    stim_valid[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (gnt[k] !== 1'b0) begin errs++; $display("FAIL reset_gnt[%0d]: got %b want 0", k, gnt[k]); end
      checks++; if (rvalid[k] !== 1'b0 || rdata[k] !== 32'h0) begin errs++; $display("FAIL reset_resp[%0d]: got %b/%h want 0/0", k, rvalid[k], rdata[k]); end
      checks++; if (stim_ready[k] !== 1'b1) begin errs++; $display("FAIL reset_ready[%0d]: got %b want 1", k, stim_ready[k]); end
      checks++; if (outstanding[k] !== 2'd0 || underflow[k] !== 1'b0 || wr_valid[k] !== 1'b0) begin errs++; $display("FAIL reset_misc[%0d]: out=%0d uf=%b wv=%b want 0", k, outstanding[k], underflow[k], wr_valid[k]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_read;
    push_word(0, 32'h00500093);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h80;
    #1;
    checks++; if (gnt[0] !== 1'b1) begin errs++; $display("FAIL read_gnt: got %b want 1", gnt[0]); end
    tick();
    req[0] = 1'b0;
    #1;
    checks++; if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h00500093) begin errs++; $display("FAIL read_resp: got %b/%h want 1/00500093", rvalid[0], rdata[0]); end
    checks++; if (outstanding[0] !== 2'd0) begin errs++; $display("FAIL read_out: got %0d want 0", outstanding[0]); end
    tick();
    checks++; if (rvalid[0] !== 1'b0) begin errs++; $display("FAIL read_rvalid_drop: got %b want 0", rvalid[0]); end
  endtask

  task automatic test_gnt_delay;
    push_word(1, 32'h11112222);
    req[1] = 1'b1; we[1] = 1'b0;
    #1;
    checks++; if (gnt[1] !== 1'b0) begin errs++; $display("FAIL gd_cycle1: got %b want 0", gnt[1]); end
    tick(); #1;
    checks++; if (gnt[1] !== 1'b0) begin errs++; $display("FAIL gd_cycle2: got %b want 0", gnt[1]); end
    tick(); #1;
    checks++; if (gnt[1] !== 1'b1) begin errs++; $display("FAIL gd_cycle3: got %b want 1", gnt[1]); end
    tick();
    req[1] = 1'b0;
    #1;
    checks++; if (rvalid[1] !== 1'b0 || outstanding[1] !== 2'd1) begin errs++; $display("FAIL gd_plus1: rvalid=%b out=%0d want 0/1", rvalid[1], outstanding[1]); end
    tick();
    checks++; if (rvalid[1] !== 1'b0) begin errs++; $display("FAIL gd_plus2: got %b want 0", rvalid[1]); end
    tick();
    checks++; if (rvalid[1] !== 1'b1 || rdata[1] !== 32'h11112222 || outstanding[1] !== 2'd0) begin errs++; $display("FAIL gd_plus3: rvalid=%b rdata=%h out=%0d want 1/11112222/0", rvalid[1], rdata[1], outstanding[1]); end
  endtask

  task automatic test_outstanding;
    for (int i = 0; i < 4; i++) push_word(2, 32'hC0DE0000 + i);
    req[2] = 1'b1; we[2] = 1'b0;
    #1;
    checks++; if (gnt[2] !== 1'b1) begin errs++; $display("FAIL os_c0: got %b want 1", gnt[2]); end
    tick(); #1;
    checks++; if (gnt[2] !== 1'b1) begin errs++; $display("FAIL os_c1: got %b want 1", gnt[2]); end
    tick(); #1;
    checks++; if (gnt[2] !== 1'b0 || outstanding[2] !== 2'd2) begin errs++; $display("FAIL os_c2: gnt=%b out=%0d want 0/2", gnt[2], outstanding[2]); end
    tick(); #1;
    checks++; if (gnt[2] !== 1'b0) begin errs++; $display("FAIL os_c3: got %b want 0", gnt[2]); end
    tick(); #1;
    checks++; if (gnt[2] !== 1'b1 || rvalid[2] !== 1'b1 || rdata[2] !== 32'hC0DE0000) begin errs++; $display("FAIL os_c4: gnt=%b rvalid=%b rdata=%h want 1/1/c0de0000", gnt[2], rvalid[2], rdata[2]); end
    tick();
    req[2] = 1'b0;
    #1;
    checks++; if (rvalid[2] !== 1'b1 || rdata[2] !== 32'hC0DE0001) begin errs++; $display("FAIL os_c5: rvalid=%b rdata=%h want 1/c0de0001", rvalid[2], rdata[2]); end
    tick();
    tick();
    checks++; if (rvalid[2] !== 1'b0) begin errs++; $display("FAIL os_c7: got %b want 0", rvalid[2]); end
    tick();
    checks++; if (rvalid[2] !== 1'b1 || rdata[2] !== 32'hC0DE0002) begin errs++; $display("FAIL os_c8: rvalid=%b rdata=%h want 1/c0de0002", rvalid[2], rdata[2]); end
    tick();
    checks++; if (rvalid[2] !== 1'b0 || outstanding[2] !== 2'd0) begin errs++; $display("FAIL os_c9: rvalid=%b out=%0d want 0/0", rvalid[2], outstanding[2]); end
  endtask

  task automatic test_write;
    push_word(0, 32'h12345678);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h00001000; wdata[0] = 32'hCAFEF00D; be[0] = 4'b0011;
    #1;
    checks++; if (gnt[0] !== 1'b1) begin errs++; $display("FAIL wr_gnt: got %b want 1", gnt[0]); end
    tick();
    req[0] = 1'b0; we[0] = 1'b0; addr[0] = 32'h0; wdata[0] = 32'h0; be[0] = 4'h0;
    #1;
    checks++; if (wr_valid[0] !== 1'b1 || wr_addr[0] !== 32'h00001000) begin errs++; $display("FAIL wr_pulse: wv=%b addr=%h want 1/00001000", wr_valid[0], wr_addr[0]); end
    checks++; if (wr_data[0] !== 32'hCAFEF00D || wr_be[0] !== 4'b0011) begin errs++; $display("FAIL wr_data: data=%h be=%b want cafef00d/0011", wr_data[0], wr_be[0]); end
    checks++; if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h0) begin errs++; $display("FAIL wr_resp: rvalid=%b rdata=%h want 1/0", rvalid[0], rdata[0]); end
    tick();
    checks++; if (wr_valid[0] !== 1'b0) begin errs++; $display("FAIL wr_pulse_end: got %b want 0", wr_valid[0]); end
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    #1;
    checks++; if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h12345678 || underflow[0] !== 1'b0) begin errs++; $display("FAIL wr_no_pop: rvalid=%b rdata=%h uf=%b want 1/12345678/0", rvalid[0], rdata[0], underflow[0]); end
  endtask

  task automatic test_fifo_full;
    for (int i = 0; i < 8; i++) push_word(0, 32'hA0 + i);
    checks++; if (stim_ready[0] !== 1'b0) begin errs++; $display("FAIL full_ready: got %b want 0", stim_ready[0]); end
    push_word(0, 32'hBAD0);
    checks++; if (stim_ready[0] !== 1'b0) begin errs++; $display("FAIL full_ignore_ready: got %b want 0", stim_ready[0]); end
    req[0] = 1'b1; we[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hA0 + i) begin errs++; $display("FAIL full_read%0d: rvalid=%b rdata=%h want 1/%h", i, rvalid[0], rdata[0], 32'hA0 + i); end
    end
    req[0] = 1'b0;
    #1;
    checks++; if (stim_ready[0] !== 1'b1 || underflow[0] !== 1'b0) begin errs++; $display("FAIL full_drained: ready=%b uf=%b want 1/0", stim_ready[0], underflow[0]); end
  endtask

  task automatic test_underflow;
    req[0] = 1'b1; we[0] = 1'b0;
    tick();
    req[0] = 1'b0;
    #1;
    checks++; if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEADBEEF) begin errs++; $display("FAIL uf_data: rvalid=%b rdata=%h want 1/deadbeef", rvalid[0], rdata[0]); end
    checks++; if (underflow[0] !== 1'b1) begin errs++; $display("FAIL uf_set: got %b want 1", underflow[0]); end
    tick(); tick(); tick();
    checks++; if (underflow[0] !== 1'b1 || rvalid[0] !== 1'b0) begin errs++; $display("FAIL uf_sticky: uf=%b rvalid=%b want 1/0", underflow[0], rvalid[0]); end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    req[2] = 1'b1; we[2] = 1'b0;
    tick(); tick();
    req[2] = 1'b0;
    #1;
    checks++; if (outstanding[2] !== 2'd2) begin errs++; $display("FAIL rm_before: got %0d want 2", outstanding[2]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (outstanding[2] !== 2'd0 || stim_ready[2] !== 1'b1) begin errs++; $display("FAIL rm_after: out=%0d ready=%b want 0/1", outstanding[2], stim_ready[2]); end
    checks++; if (underflow[0] !== 1'b0) begin errs++; $display("FAIL rm_uf_clear: got %b want 0", underflow[0]); end
    for (int i = 0; i < 6; i++) begin
      if (rvalid[2] !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errs++; $display("FAIL rm_no_rvalid: got %0d responses want 0", seen); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; stim_valid[k] = 1'b0;
      addr[k] = '0; wdata[k] = '0; stim_data[k] = '0; be[k] = '0;
    end
    test_reset();
    test_read();
    test_gnt_delay();
    test_outstanding();
    test_write();
    test_fifo_full();
    test_underflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
